aes_core_arb: RTL and testbench

- Shares one AES-128 ECB encrypt core between two requesters:
  - requester 0: the Block_Cipher_df engine (BCC chaining and final X = AES(K, X) loop);
  - requester 1: the CTR_DRBG update/generate path.
- Runs one encryption at a time, with fair round-robin grant, a timeout watchdog on the core, and a response routed back to the requester that issued the block.
- Sits between the DRBG datapath blocks and the single aes_core instance.

---
 rtl/aes_core_arb.sv | 158 +++++++++++++++
 tb/tb_aes_core_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arb.sv
// Round-robin arbiter sharing one AES-128 encrypt core between the Block_Cipher_df
// engine (requester 0) and the CTR_DRBG update/generate path (requester 1).
module aes_core_arb #(
    parameter  int TIMEOUT = 64,
    localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [127:0] req0_key_i,
    input  logic [127:0] req0_block_i,
    output logic         rsp0_valid_o,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [127:0] req1_key_i,
    input  logic [127:0] req1_block_i,
    output logic         rsp1_valid_o,
    output logic [127:0] rsp_data_o,
    output logic         rsp_err_o,
    output logic         aes_start_o,
    output logic [127:0] aes_key_o,
    output logic [127:0] aes_block_o,
    input  logic         aes_done_i,
    input  logic [127:0] aes_result_i,
    output logic         busy_o,
    output logic         err_sticky_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic            last_gnt_r;
    logic            owner_r;
    logic [127:0]    key_r;
    logic [127:0]    block_r;
    logic [127:0]    data_r;
    logic            err_r;
    logic            err_sticky_r;
    logic [TO_W-1:0] cnt_r;
    logic            start_r;
    logic            busy_r;
    logic            rsp0_r;
    logic            rsp1_r;

    logic            gnt_valid_s;
    logic            gnt_id_s;

    // Grant decision: only in IDLE and never while reset is held, so ready stays 0 in reset.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = ~last_gnt_r;
            end else if (req0_valid_i) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b0;
            end else if (req1_valid_i) begin
                gnt_valid_s = 1'b1;
                gnt_id_s    = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
                gnt_id_s    = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
        end
    end

    assign req0_ready_o = gnt_valid_s & ~gnt_id_s;
    assign req1_ready_o = gnt_valid_s & gnt_id_s;

    // Operation sequencer; every core-facing and response output is a register set on the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_gnt_r   <= 1'b1;
            owner_r      <= 1'b0;
            key_r        <= 128'd0;
            block_r      <= 128'd0;
            data_r       <= 128'd0;
            err_r        <= 1'b0;
            err_sticky_r <= 1'b0;
            cnt_r        <= {TO_W{1'b0}};
            start_r      <= 1'b0;
            busy_r       <= 1'b0;
            rsp0_r       <= 1'b0;
            rsp1_r       <= 1'b0;
        end else begin
            start_r <= 1'b0;
            rsp0_r  <= 1'b0;
            rsp1_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        key_r      <= gnt_id_s ? req1_key_i : req0_key_i;
                        block_r    <= gnt_id_s ? req1_block_i : req0_block_i;
                        owner_r    <= gnt_id_s;
                        last_gnt_r <= gnt_id_s;
                        start_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= {TO_W{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the final watchdog cycle still counts as a good result.
                    if (aes_done_i) begin
                        data_r  <= aes_result_i;
                        err_r   <= 1'b0;
                        rsp0_r  <= ~owner_r;
                        rsp1_r  <= owner_r;
                        state_r <= ST_RESP;
                    end else if (cnt_r == TO_W'(TIMEOUT - 1)) begin
                        data_r       <= 128'd0;
                        err_r        <= 1'b1;
                        err_sticky_r <= 1'b1;
                        rsp0_r       <= ~owner_r;
                        rsp1_r       <= owner_r;
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid_o = rsp0_r;
    assign rsp1_valid_o = rsp1_r;
    assign rsp_data_o   = data_r;
    assign rsp_err_o    = err_r;
    assign aes_start_o  = start_r;
    assign aes_key_o    = key_r;
    assign aes_block_o  = block_r;
    assign busy_o       = busy_r;
    assign err_sticky_o = err_sticky_r;

endmodule

// File: tb/tb_aes_core_arb.sv
// Self-checking bench for aes_core_arb: stub AES core with programmable latency,
// vector table, directed corner sequences and a randomized timeline model.
module tb_aes_core_arb;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid_i, req0_ready_o, rsp0_valid_o;
    logic [127:0] req0_key_i, req0_block_i;
    logic         req1_valid_i, req1_ready_o, rsp1_valid_o;
    logic [127:0] req1_key_i, req1_block_i;
    logic [127:0] rsp_data_o;
    logic         rsp_err_o;
    logic         aes_start_o;
    logic [127:0] aes_key_o, aes_block_o;
    logic         aes_done_i;
    logic [127:0] aes_result_i;
    logic         busy_o, err_sticky_o;

    int n_vec = 0;
    int n_err = 0;
    int core_lat = 0;   // 0 = core never finishes
    bit inject = 1'b0;

    aes_core_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_key_i(req0_key_i), .req0_block_i(req0_block_i), .rsp0_valid_o(rsp0_valid_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_key_i(req1_key_i), .req1_block_i(req1_block_i), .rsp1_valid_o(rsp1_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .aes_start_o(aes_start_o), .aes_key_o(aes_key_o), .aes_block_o(aes_block_o),
        .aes_done_i(aes_done_i), .aes_result_i(aes_result_i),
        .busy_o(busy_o), .err_sticky_o(err_sticky_o)
    );

    always #5 clk = ~clk;

    // Stub core: known answer for the FIPS-197 vector, a cheap keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] b);
        if (k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
        return {b[63:0], b[127:64]} ^ k ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin : stub_core
        int cyc;
        int due;
        bit pend;
        logic [127:0] res;
        cyc = 0; due = 0; pend = 1'b0; res = 128'd0;
        aes_done_i = 1'b0; aes_result_i = 128'd0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            aes_done_i = (pend && cyc == due) || inject;
            if (pend && cyc == due) pend = 1'b0;
            aes_result_i = aes_done_i ? res : ~res;
            if (aes_start_o) begin
                res = core_fn(aes_key_o, aes_block_o);
                pend = (core_lat > 0);
                due = cyc + core_lat;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready0"}, req0_ready_o, 1'b0);
        chk({tag, "_ready1"}, req1_ready_o, 1'b0);
        chk({tag, "_rsp0"}, rsp0_valid_o, 1'b0);
        chk({tag, "_rsp1"}, rsp1_valid_o, 1'b0);
        chk({tag, "_data"}, rsp_data_o, 128'd0);
        chk({tag, "_err"}, rsp_err_o, 1'b0);
        chk({tag, "_start"}, aes_start_o, 1'b0);
        chk({tag, "_key"}, aes_key_o, 128'd0);
        chk({tag, "_block"}, aes_block_o, 128'd0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_sticky"}, err_sticky_o, 1'b0);
    endtask

    typedef struct {
        bit           v0, v1;
        logic [127:0] k0, b0, k1, b1;
        int           lat;
        bit           own;
        bit           err;
        logic [127:0] data;
        int           exp_lat;
        bit           sticky;
    } vec_t;

    vec_t vecs[8];

    task automatic set_vec(input int i, input bit v0, input bit v1, input int lat,
                           input bit own, input bit err, input int elat, input bit st);
        vecs[i].v0 = v0; vecs[i].v1 = v1;
        vecs[i].k0 = rnd128(); vecs[i].b0 = rnd128();
        vecs[i].k1 = rnd128(); vecs[i].b1 = rnd128();
        vecs[i].lat = lat; vecs[i].own = own; vecs[i].err = err;
        vecs[i].exp_lat = elat; vecs[i].sticky = st;
        vecs[i].data = err ? 128'd0 : core_fn(own ? vecs[i].k1 : vecs[i].k0,
                                             own ? vecs[i].b1 : vecs[i].b0);
    endtask

    // One operation from an idle arbiter: accept at T, start at T+1, response at T+exp_lat.
    task automatic run_vec(input vec_t v);
        int n;
        bit found;
        tick();
        req0_valid_i = v.v0; req0_key_i = v.k0; req0_block_i = v.b0;
        req1_valid_i = v.v1; req1_key_i = v.k1; req1_block_i = v.b1;
        core_lat = v.lat;
        #1;
        chk("vec_ready0", req0_ready_o, v.own == 1'b0);
        chk("vec_ready1", req1_ready_o, v.own == 1'b1);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        #1;
        chk("vec_start", aes_start_o, 1'b1);
        chk("vec_busy", busy_o, 1'b1);
        chk("vec_core_key", aes_key_o, v.own ? v.k1 : v.k0);
        chk("vec_core_block", aes_block_o, v.own ? v.b1 : v.b0);
        n = 1; found = 1'b0;
        while (!found && n < 200) begin
            tick(); #1; n++;
            if (rsp0_valid_o || rsp1_valid_o) found = 1'b1;
        end
        chk("vec_latency", n, v.exp_lat);
        chk("vec_rsp0", rsp0_valid_o, v.own == 1'b0);
        chk("vec_rsp1", rsp1_valid_o, v.own == 1'b1);
        chk("vec_data", rsp_data_o, v.data);
        chk("vec_err", rsp_err_o, v.err);
        chk("vec_sticky", err_sticky_o, v.sticky);
        chk("vec_resp_busy", busy_o, 1'b1);
        tick(); #1;
        chk("vec_idle_busy", busy_o, 1'b0);
        chk("vec_idle_rsp", rsp0_valid_o | rsp1_valid_o, 1'b0);
    endtask

    initial begin
        bit want0, want1, g_any, g_id, m_last, m_owner, g;
        logic [127:0] wk0, wb0, wk1, wb1, m_data, ka, kb;
        logic [128:0] q[$];
        logic [128:0] e;
        int m_free, m_resp, m_acc, lat, ngr, nresp;
        bit new0, new1;

        rst = 1'b1;
        req0_valid_i = 1'b1; req0_key_i = FIPS_KEY; req0_block_i = FIPS_PT;
        req1_valid_i = 1'b1; req1_key_i = 128'd0; req1_block_i = 128'd0;

        set_vec(0, 1'b1, 1'b0, 11, 1'b0, 1'b0, 13, 1'b0);
        vecs[0].k0 = FIPS_KEY; vecs[0].b0 = FIPS_PT; vecs[0].data = FIPS_CT;
        set_vec(1, 1'b1, 1'b1, 3,  1'b1, 1'b0, 5,  1'b0);
        set_vec(2, 1'b1, 1'b1, 1,  1'b0, 1'b0, 3,  1'b0);
        set_vec(3, 1'b1, 1'b1, 64, 1'b1, 1'b0, 66, 1'b0);
        set_vec(4, 1'b0, 1'b1, 5,  1'b1, 1'b0, 7,  1'b0);
        set_vec(5, 1'b1, 1'b0, 0,  1'b0, 1'b1, 66, 1'b1);
        set_vec(6, 1'b0, 1'b1, 2,  1'b1, 1'b0, 4,  1'b1);
        set_vec(7, 1'b1, 1'b1, 65, 1'b0, 1'b1, 66, 1'b1);

        tick(); tick(); #1;
        chk_zero("reset");
        tick();
        rst = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stale done while idle after the timeouts.
        tick(); tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            #1;
            chk("late_rsp", rsp0_valid_o | rsp1_valid_o, 1'b0);
            chk("late_busy", busy_o, 1'b0);
            chk("late_sticky", err_sticky_o, 1'b1);
        end

        // Reset five cycles after the start pulse; the core's done arrives later in IDLE.
        tick();
        req0_valid_i = 1'b1; req0_key_i = rnd128(); req0_block_i = rnd128(); core_lat = 20;
        #1; chk("rw_ready0", req0_ready_o, 1'b1);
        tick();
        req0_valid_i = 1'b0;
        #1; chk("rw_start", aes_start_o, 1'b1);
        repeat (5) tick();
        rst = 1'b1; req0_valid_i = 1'b1;
        #1; chk_zero("rst_mid");
        tick(); tick();
        rst = 1'b0; req0_valid_i = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(); #1;
            chk("rw_no_rsp", rsp0_valid_o | rsp1_valid_o, 1'b0);
            chk("rw_busy", busy_o, 1'b0);
        end

        // Continuous contention after reset: grants 0,1,0,1.
        ngr = 0; nresp = 0; new0 = 1'b1; new1 = 1'b1; core_lat = 4;
        for (int n = 0; n < 100 && nresp < 4; n++) begin
            tick();
            req0_valid_i = 1'b1; req1_valid_i = 1'b1;
            if (new0) begin req0_key_i = rnd128(); req0_block_i = rnd128(); new0 = 1'b0; end
            if (new1) begin req1_key_i = rnd128(); req1_block_i = rnd128(); new1 = 1'b0; end
            #1;
            chk("cont_both_ready", req0_ready_o & req1_ready_o, 1'b0);
            if (req0_ready_o || req1_ready_o) begin
                g = req1_ready_o;
                chk("cont_grant", g, ngr % 2);
                q.push_back({g, g ? core_fn(req1_key_i, req1_block_i)
                                  : core_fn(req0_key_i, req0_block_i)});
                if (g) new1 = 1'b1; else new0 = 1'b1;
                ngr++;
            end
            if (rsp0_valid_o || rsp1_valid_o) begin
                if (q.size() == 0) begin
                    chk("cont_spurious_rsp", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("cont_rsp0", rsp0_valid_o, e[128] == 1'b0);
                    chk("cont_rsp1", rsp1_valid_o, e[128] == 1'b1);
                    chk("cont_data", rsp_data_o, e[127:0]);
                    chk("cont_err", rsp_err_o, 1'b0);
                end
                nresp++;
            end
        end
        chk("cont_count", nresp, 4);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;

        // Withdrawn req1 during service, then req0 re-asserted right after its RESP.
        ka = rnd128(); kb = rnd128();
        for (int k = 0; k < 15; k++) begin
            tick();
            case (k)
                0: begin req0_valid_i = 1'b1; req0_key_i = ka; req0_block_i = ka; core_lat = 6; end
                1: req0_valid_i = 1'b0;
                3: begin req1_valid_i = 1'b1; req1_key_i = rnd128(); end
                4: req1_valid_i = 1'b0;
                9: begin req0_valid_i = 1'b1; req0_key_i = kb; req0_block_i = ka; core_lat = 2; end
                10: req0_valid_i = 1'b0;
                default: ;
            endcase
            #1;
            chk("wd_ready1", req1_ready_o, 1'b0);
            chk("wd_ready0", req0_ready_o, k == 0 || k == 9);
            chk("wd_rsp0", rsp0_valid_o, k == 8 || k == 13);
            chk("wd_rsp1", rsp1_valid_o, 1'b0);
            if (k == 8)  chk("wd_data_a", rsp_data_o, core_fn(ka, ka));
            if (k == 13) chk("wd_data_b", rsp_data_o, core_fn(kb, ka));
        end

        // Randomized traffic against a transaction timeline model.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        want0 = 1'b0; want1 = 1'b0; wk0 = 128'd0; wb0 = 128'd0; wk1 = 128'd0; wb1 = 128'd0;
        m_free = 0; m_resp = -1; m_acc = -1; m_last = 1'b1; m_owner = 1'b0; m_data = 128'd0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!want0 && $urandom_range(0, 2) == 0) begin want0 = 1'b1; wk0 = rnd128(); wb0 = rnd128(); end
            if (!want1 && $urandom_range(0, 2) == 0) begin want1 = 1'b1; wk1 = rnd128(); wb1 = rnd128(); end
            req0_valid_i = want0; req0_key_i = wk0; req0_block_i = wb0;
            req1_valid_i = want1; req1_key_i = wk1; req1_block_i = wb1;
            g_any = (c >= m_free) && (want0 || want1);
            g_id  = (want0 && want1) ? ~m_last : want1;
            #1;
            chk("rnd_ready0", req0_ready_o, g_any && !g_id);
            chk("rnd_ready1", req1_ready_o, g_any && g_id);
            chk("rnd_rsp0", rsp0_valid_o, c == m_resp && !m_owner);
            chk("rnd_rsp1", rsp1_valid_o, c == m_resp && m_owner);
            chk("rnd_busy", busy_o, c > m_acc && c <= m_resp);
            if (c == m_resp) begin
                chk("rnd_data", rsp_data_o, m_data);
                chk("rnd_err", rsp_err_o, 1'b0);
            end
            if (g_any) begin
                lat = $urandom_range(1, 12);
                core_lat = lat;
                m_last = g_id; m_owner = g_id; m_acc = c;
                m_resp = c + 2 + lat; m_free = m_resp + 1;
                m_data = g_id ? core_fn(wk1, wb1) : core_fn(wk0, wb0);
                if (g_id) want1 = 1'b0; else want0 = 1'b0;
            end
        end
        chk("rnd_sticky", err_sticky_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
